stream_demux_1_4: RTL and testbench

Registered 1-to-4 stream demultiplexer with valid/ready handshakes. It is the distributing counterpart of the 4:1 data multiplexer. A single input stream carries a WIDTH-bit word and a 2-bit destination select, and the block steers each accepted word into one of four independent output slots. It sits between a shared producer and four consumers that may stall independently, and keeps per-output delivery counts for status and debug.

---
 rtl/stream_demux_1_4.sv | 80 ++++++++
 tb/tb_stream_demux_1_4.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 valid/ready stream demultiplexer: four independent one-entry
// output slots, each with a wrapping delivery counter.
module stream_demux_1_4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_d0,
  output logic [WIDTH-1:0] out_d1,
  output logic [WIDTH-1:0] out_d2,
  output logic [WIDTH-1:0] out_d3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [3:0]       full_q, full_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic [3:0]       out_fire;
  logic             in_fire;

  // Only the addressed slot gates the input; a draining slot can take a new word.
  assign in_ready = !full_q[in_sel] || out_ready[in_sel];
  assign in_fire  = in_valid && in_ready;
  assign out_fire = full_q & out_ready;

  always_comb begin
    full_d = full_q;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      cnt_d[k]  = cnt_q[k];
      if (out_fire[k]) begin
        full_d[k] = 1'b0;
        cnt_d[k]  = cnt_q[k] + CNT_W'(1);
      end
      if (in_fire && (in_sel == 2'(k))) begin
        full_d[k] = 1'b1;
        data_d[k] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign out_valid = full_q;
  assign out_d0    = data_q[0];
  assign out_d1    = data_q[1];
  assign out_d2    = data_q[2];
  assign out_d3    = data_q[3];
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: a per-destination scoreboard of
// accepted words plus a small slot model, checked every cycle.
module tb_stream_demux_1_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [3:0] out_d0, out_d1, out_d2, out_d3;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] sbq [4][$];
  logic       mfull [4];
  logic [3:0] mlast [4];
  logic [7:0] mcnt  [4];

  stream_demux_1_4 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] dut_d(input int k);
    case (k)
      0: return out_d0;
      1: return out_d1;
      2: return out_d2;
      default: return out_d3;
    endcase
  endfunction

  function automatic logic [7:0] dut_cnt(input int k);
    case (k)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      default: return cnt3;
    endcase
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      sbq[k].delete();
      mfull[k] = 1'b0;
      mlast[k] = '0;
      mcnt[k]  = '0;
    end
  endtask

  // Asserts rst_n between clock edges and checks the outputs clear immediately.
  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 4'b0000);
    check_val("rst_out_d2", out_d2, 4'h0);
    check_val("rst_cnt2", cnt2, 8'd0);
    check_val("rst_in_ready", in_ready, 1'b1);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive at negedge, check against the model, then predict the edge.
  task automatic step(input bit v, input logic [1:0] s, input logic [3:0] d,
                      input logic [3:0] ordy);
    logic       exp_rdy;
    logic [3:0] word;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_rdy = !mfull[s] || ordy[s];
    check_val("in_ready", in_ready, exp_rdy);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("out_valid%0d", k), out_valid[k], mfull[k]);
      check_val($sformatf("out_d%0d", k), dut_d(k), mlast[k]);
      check_val($sformatf("cnt%0d", k), dut_cnt(k), mcnt[k]);
      if (mfull[k] && ordy[k]) begin
        check_val($sformatf("sb_nonempty%0d", k), sbq[k].size() != 0, 1);
        if (sbq[k].size() != 0) begin
          word = sbq[k].pop_front();
          check_val($sformatf("sb_data%0d", k), dut_d(k), word);
        end
        mcnt[k]++;
        mfull[k] = 1'b0;
      end
    end
    if (v && exp_rdy) begin
      sbq[s].push_back(d);
      mfull[s] = 1'b1;
      mlast[s] = d;
    end
  endtask

  initial begin
    clear_model();
    apply_reset();

    // mid-stream reset with slot 2 holding 4'hA
    step(1, 2'd2, 4'hA, 4'h0);
    step(0, 2'd0, 4'h0, 4'h0);
    check_val("pre_rst_d2", out_d2, 4'hA);
    apply_reset();

    // basic routing
    step(1, 2'd0, 4'h1, 4'hF);
    step(1, 2'd1, 4'h2, 4'hF);
    step(1, 2'd2, 4'h3, 4'hF);
    step(1, 2'd3, 4'h4, 4'hF);
    step(0, 2'd0, 4'h0, 4'hF);
    step(0, 2'd0, 4'h0, 4'hF);
    check_val("basic_cnt0", cnt0, 8'd1);
    check_val("basic_cnt1", cnt1, 8'd1);
    check_val("basic_cnt2", cnt2, 8'd1);
    check_val("basic_cnt3", cnt3, 8'd1);
    check_val("basic_d3", out_d3, 4'h4);

    // backpressure on slot 1, then replace-while-draining
    step(1, 2'd1, 4'h5, 4'b1101);
    step(1, 2'd1, 4'h6, 4'b1101);
    check_val("bp_blocked", in_ready, 1'b0);
    check_val("bp_hold_d1", out_d1, 4'h5);
    step(1, 2'd1, 4'h6, 4'hF);
    check_val("bp_accept", in_ready, 1'b1);
    step(0, 2'd0, 4'h0, 4'b0000);
    check_val("bp_valid1", out_valid[1], 1'b1);
    check_val("bp_d1", out_d1, 4'h6);
    step(0, 2'd0, 4'h0, 4'hF);

    // independence: slot 0 stalled, slot 3 still flows
    step(1, 2'd0, 4'h8, 4'b0000);
    step(1, 2'd3, 4'h7, 4'b1110);
    check_val("ind_accept", in_ready, 1'b1);
    step(0, 2'd0, 4'h0, 4'b1110);
    check_val("ind_d3", out_d3, 4'h7);
    check_val("ind_d0", out_d0, 4'h8);
    check_val("ind_valid0", out_valid[0], 1'b1);
    step(0, 2'd0, 4'h0, 4'hF);

    // counter wrap on slot 2
    apply_reset();
    for (int i = 0; i < 256; i++) step(1, 2'd2, 4'(i), 4'hF);
    step(0, 2'd0, 4'h0, 4'hF);
    step(0, 2'd0, 4'h0, 4'hF);
    check_val("wrap_cnt2_256", cnt2, 8'd0);
    step(1, 2'd2, 4'hC, 4'hF);
    step(0, 2'd0, 4'h0, 4'hF);
    step(0, 2'd0, 4'h0, 4'hF);
    check_val("wrap_cnt2_257", cnt2, 8'd1);

    // random traffic
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom));
    step(0, 2'd0, 4'h0, 4'hF);
    step(0, 2'd0, 4'h0, 4'hF);
    for (int k = 0; k < 4; k++)
      check_val($sformatf("drain_sb%0d", k), sbq[k].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
